// File: rtl/demux_fifo_n_if.sv
// Bus bundle for demux_fifo_n: one shared write port, per-channel pop strobes and status.
// The master side is the producer/consumer environment; the slave side is the demux itself.
interface demux_fifo_n_if #(
    parameter int BITNUMBER = 5,
    parameter int CHANNELS  = 4,
    parameter int SELW      = 2
);
    logic                          valid_in;
    logic [SELW-1:0]               sel_in;
    logic [BITNUMBER-1:0]          data_in;
    logic [CHANNELS-1:0]           pop;
    logic [CHANNELS*BITNUMBER-1:0] data_out;
    logic [CHANNELS-1:0]           valid_out;
    logic [CHANNELS-1:0]           full;
    logic [7:0]                    drop_count;

    modport master (
        output valid_in, sel_in, data_in, pop,
        input  data_out, valid_out, full, drop_count
    );

    modport slave (
        input  valid_in, sel_in, data_in, pop,
        output data_out, valid_out, full, drop_count
    );
endinterface

// File: rtl/demux_fifo_n.sv
// Routes a single input word stream into CHANNELS first-word-fall-through FIFOs,
// dropping (and counting) words aimed at a missing or full channel.
module demux_fifo_n #(
    parameter int BITNUMBER = 5,
    parameter int CHANNELS  = 4,
    parameter int SELW      = 2,
    parameter int DEPTH     = 4
) (
    input logic           clk,
    input logic           reset,
    demux_fifo_n_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [BITNUMBER-1:0] mem_q    [CHANNELS][DEPTH];
    logic [BITNUMBER-1:0] mem_d    [CHANNELS][DEPTH];
    logic [PW-1:0]        rd_ptr_q [CHANNELS];
    logic [PW-1:0]        rd_ptr_d [CHANNELS];
    logic [PW-1:0]        wr_ptr_q [CHANNELS];
    logic [PW-1:0]        wr_ptr_d [CHANNELS];
    logic [CW-1:0]        count_q  [CHANNELS];
    logic [CW-1:0]        count_d  [CHANNELS];
    logic [7:0]           drop_count_q;
    logic [7:0]           drop_count_d;

    logic sel_ok;
    logic drop;
    logic wr_k;
    logic pop_k;

    // A full channel still accepts a write when its head is popped in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_k     = 1'b0;
        pop_k    = 1'b0;
        sel_ok   = (32'(bus.sel_in) < CHANNELS);
        drop     = bus.valid_in && !sel_ok;

        for (int k = 0; k < CHANNELS; k++) begin
            wr_k  = 1'b0;
            pop_k = bus.pop[k] && (count_q[k] != '0);
            if (bus.valid_in && sel_ok && (32'(bus.sel_in) == k)) begin
                if ((count_q[k] != CW'(DEPTH)) || bus.pop[k]) begin
                    wr_k = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            if (wr_k) begin
                mem_d[k][wr_ptr_q[k]] = bus.data_in;
                wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
            end
            if (pop_k) begin
                rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
            end
            count_d[k] = count_q[k] + CW'(wr_k) - CW'(pop_k);
        end

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q        <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            wr_ptr_q     <= '{default: '0};
            count_q      <= '{default: '0};
            drop_count_q <= 8'd0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Heads are gated to zero on empty channels so stale memory never leaks out.
    always_comb begin
        bus.data_out  = '0;
        bus.valid_out = '0;
        bus.full      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.valid_out[k] = (count_q[k] != '0);
            bus.full[k]      = (count_q[k] == CW'(DEPTH));
            if (count_q[k] != '0) begin
                bus.data_out[k*BITNUMBER +: BITNUMBER] = mem_q[k][rd_ptr_q[k]];
            end
        end
    end

    assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_demux_fifo_n.sv
// Directed bench for demux_fifo_n: a 4-channel instance for routing/FIFO behaviour and a
// 3-channel instance for out-of-range selects and drop counter saturation.
module tb_demux_fifo_n;
    logic clk;
    logic reset;
    int   numCompared;
    int   numMismatched;
    int   expHead[4];

    demux_fifo_n_if #(.BITNUMBER(5), .CHANNELS(4), .SELW(2)) ifa ();
    demux_fifo_n_if #(.BITNUMBER(5), .CHANNELS(3), .SELW(2)) ifb ();

    demux_fifo_n #(.BITNUMBER(5), .CHANNELS(4), .SELW(2), .DEPTH(4)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    demux_fifo_n #(.BITNUMBER(5), .CHANNELS(3), .SELW(2), .DEPTH(4)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] headA(input int k);
        return ifa.data_out[k*5 +: 5];
    endfunction

    function automatic logic [4:0] headB(input int k);
        return ifb.data_out[k*5 +: 5];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle on the chosen instance (0 = 4-channel, 1 = 3-channel), then idles it.
    task automatic applyStimulus(input bit target, input logic valid, input logic [1:0] sel,
                                 input logic [4:0] data, input logic [3:0] popMask);
        if (target == 1'b0) begin
            ifa.valid_in = valid;
            ifa.sel_in   = sel;
            ifa.data_in  = data;
            ifa.pop      = popMask;
        end else begin
            ifb.valid_in = valid;
            ifb.sel_in   = sel;
            ifb.data_in  = data;
            ifb.pop      = popMask[2:0];
        end
        @(posedge clk);
        #1;
        ifa.valid_in = 1'b0;
        ifa.sel_in   = '0;
        ifa.data_in  = '0;
        ifa.pop      = '0;
        ifb.valid_in = 1'b0;
        ifb.sel_in   = '0;
        ifb.data_in  = '0;
        ifb.pop      = '0;
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        reset         = 1'b0;
        ifa.valid_in  = 1'b0;
        ifa.sel_in    = '0;
        ifa.data_in   = '0;
        ifa.pop       = '0;
        ifb.valid_in  = 1'b0;
        ifb.sel_in    = '0;
        ifb.data_in   = '0;
        ifb.pop       = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", ifa.valid_out, 0);
        checkOutput("rst_full", ifa.full, 0);
        checkOutput("rst_data", ifa.data_out, 0);
        checkOutput("rst_drop", ifa.drop_count, 0);
        checkOutput("rst_validB", ifb.valid_out, 0);
        reset = 1'b1;

        // Basic routing, first edge after release must accept
        applyStimulus(0, 1, 0, 5, 4'b0000);
        checkOutput("route_head0", headA(0), 5);
        checkOutput("route_valid1", ifa.valid_out, 4'b0001);
        applyStimulus(0, 1, 1, 7, 4'b0000);
        checkOutput("route_head1", headA(1), 7);
        checkOutput("route_head0_kept", headA(0), 5);
        checkOutput("route_valid2", ifa.valid_out, 4'b0011);
        checkOutput("route_drop", ifa.drop_count, 0);
        applyStimulus(0, 0, 0, 0, 4'b0011);
        checkOutput("dual_pop_valid", ifa.valid_out, 0);
        checkOutput("dual_pop_data", ifa.data_out, 0);
        applyStimulus(0, 0, 2, 31, 4'b0000);
        checkOutput("idle_ignored", ifa.valid_out, 0);

        // Fill channel 2 and overflow it
        expHead = '{3, 4, 5, 6};
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 2, 5'(expHead[i]), 4'b0000);
        checkOutput("fill_full", ifa.full, 4'b0100);
        checkOutput("fill_valid", ifa.valid_out, 4'b0100);
        applyStimulus(0, 1, 2, 9, 4'b0000);
        checkOutput("ovf_drop", ifa.drop_count, 1);
        checkOutput("ovf_full", ifa.full, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_drain_head", headA(2), 32'(expHead[i]));
            applyStimulus(0, 0, 0, 0, 4'b0100);
        end
        checkOutput("ovf_empty_valid", ifa.valid_out, 0);
        checkOutput("ovf_empty_full", ifa.full, 0);

        // Full channel 1 with write and pop together: pass-through
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 1, 5'(i), 4'b0000);
        checkOutput("pt_full_before", ifa.full, 4'b0010);
        applyStimulus(0, 1, 1, 9, 4'b0010);
        checkOutput("pt_head", headA(1), 2);
        checkOutput("pt_full_after", ifa.full, 4'b0010);
        checkOutput("pt_drop", ifa.drop_count, 1);
        expHead = '{2, 3, 4, 9};
        for (int i = 0; i < 4; i++) begin
            checkOutput("pt_drain_head", headA(1), 32'(expHead[i]));
            applyStimulus(0, 0, 0, 0, 4'b0010);
        end
        checkOutput("pt_empty", ifa.valid_out, 0);

        // Write plus pop on an empty channel: pop ignored, write kept
        applyStimulus(0, 1, 3, 12, 4'b1000);
        checkOutput("empty_wp_valid", ifa.valid_out, 4'b1000);
        checkOutput("empty_wp_head", headA(3), 12);
        applyStimulus(0, 0, 0, 0, 4'b1000);
        checkOutput("empty_wp_drain", ifa.valid_out, 0);

        // Mid-run asynchronous reset
        applyStimulus(0, 1, 0, 13, 4'b0000);
        applyStimulus(0, 1, 0, 14, 4'b0000);
        checkOutput("mid_head_before", headA(0), 13);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", ifa.valid_out, 0);
        checkOutput("mid_rst_data", ifa.data_out, 0);
        checkOutput("mid_rst_drop", ifa.drop_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(0, 1, 0, 4, 4'b0000);
        checkOutput("post_rst_head", headA(0), 4);
        checkOutput("post_rst_valid", ifa.valid_out, 4'b0001);
        applyStimulus(0, 0, 0, 0, 4'b0001);
        checkOutput("post_rst_second", ifa.valid_out, 0);

        // 3-channel instance: empty pops, bad select, saturation
        applyStimulus(1, 0, 0, 0, 4'b0111);
        checkOutput("b_empty_pop_valid", ifb.valid_out, 0);
        checkOutput("b_empty_pop_drop", ifb.drop_count, 0);
        applyStimulus(1, 1, 0, 6, 4'b0000);
        checkOutput("b_write_valid", ifb.valid_out, 3'b001);
        applyStimulus(1, 1, 3, 20, 4'b0000);
        checkOutput("b_badsel_drop", ifb.drop_count, 1);
        checkOutput("b_badsel_valid", ifb.valid_out, 3'b001);
        for (int i = 0; i < 253; i++) applyStimulus(1, 1, 3, 5'(i), 4'b0000);
        checkOutput("b_sat_254", ifb.drop_count, 254);
        applyStimulus(1, 1, 3, 1, 4'b0000);
        checkOutput("b_sat_255", ifb.drop_count, 255);
        for (int i = 0; i < 50; i++) applyStimulus(1, 1, 3, 5'(i), 4'b0000);
        checkOutput("b_sat_hold", ifb.drop_count, 255);
        checkOutput("b_head_kept", headB(0), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end
endmodule

// File: doc/demux_fifo_n.md
DEMUX_FIFO_N -- requirements
Module: demux_fifo_n

Interface
REQ-001 SHALL provide parameter BITNUMBER, default 5, data word width.
REQ-002 SHALL provide parameter CHANNELS, default 4, number of output channels (2..16).
REQ-003 SHALL provide parameter SELW, default 2, select width (2^SELW >= CHANNELS).
REQ-004 SHALL provide parameter DEPTH, default 4, per-channel FIFO depth (power of 2, >= 2).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port valid_in, input, 1, input word present this cycle.
REQ-008 SHALL have port sel_in, input, SELW, destination channel index.
REQ-009 SHALL have port data_in, input, BITNUMBER, input word.
REQ-010 SHALL have port pop, input, CHANNELS, per-channel read strobe from consumer.
REQ-011 SHALL have port data_out, output, CHANNELS*BITNUMBER, per-channel head word; channel k in bits [k*BITNUMBER +: BITNUMBER].
REQ-012 SHALL have port valid_out, output, CHANNELS, per-channel FIFO non-empty.
REQ-013 SHALL have port full, output, CHANNELS, per-channel FIFO occupancy == DEPTH.
REQ-014 SHALL have port drop_count, output, 8, saturating count of discarded input words.

Function
REQ-015 SHALL write data_in into FIFO[sel_in] on a rising edge when valid_in=1, sel_in<CHANNELS and (full[sel_in]=0 or pop[sel_in]=1).
REQ-016 SHALL present each FIFO first-word-fall-through: data_out[k] = oldest stored word whenever valid_out[k]=1.
REQ-017 SHALL drive data_out[k] to 0 when valid_out[k]=0.
REQ-018 SHALL make a word written at edge N visible on valid_out/data_out immediately after edge N (one-cycle write latency).
REQ-019 SHALL remove the head of FIFO[k] on a rising edge when pop[k]=1 and valid_out[k]=1.
REQ-020 SHALL ignore pop[k] when valid_out[k]=0 (no underflow, no state change).
REQ-021 SHALL, on simultaneous write and pop to the same channel, perform both; occupancy unchanged; allowed when full (pass-through into freed slot), not when empty (pop ignored, write accepted).
REQ-022 SHALL process pops on all channels independently in the same cycle.
REQ-023 SHALL discard the word and increment drop_count when valid_in=1 and either sel_in>=CHANNELS or (full[sel_in]=1 and pop[sel_in]=0).
REQ-024 SHALL saturate drop_count at 255; no wrap.
REQ-025 SHALL track occupancy per channel in log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
REQ-026 SHALL keep words of each channel strictly in arrival order; no reordering across or within channels.
REQ-027 SHALL ignore sel_in and data_in when valid_in=0.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear all pointers and occupancies, valid_out=0, full=0, data_out=0, drop_count=0.
REQ-029 SHALL, on reset assertion mid-operation, discard all stored words; no word stored before reset appears after release.
REQ-030 SHALL accept writes on the first rising edge after reset returns to 1.

Verification
REQ-031 Basic route: reset release, valid_in=1 sel_in=0 data_in=5, then sel_in=1 data_in=7 -> data_out[0]=5 valid_out=0001 after edge 1; data_out[1]=7 valid_out=0011 after edge 2; drop_count=0.
REQ-032 Fill and overflow: 5 writes to channel 2 (3,4,5,6,9), no pop, DEPTH=4 -> full[2]=1 after 4th edge; 5th word dropped, drop_count=1; pops return 3,4,5,6 in order then valid_out[2]=0.
REQ-033 Full pass-through: channel 1 full, valid_in=1 sel_in=1 data_in=9 with pop[1]=1 -> head advances, 9 becomes tail, full[1] stays 1, drop_count unchanged.
REQ-034 Bad select and empty pop: CHANNELS=3, sel_in=3 valid_in=1 -> drop_count +1, no valid_out change; pop=111 with all empty -> no state change.
REQ-035 Saturation: 300 dropped words -> drop_count=255 and holds.
REQ-036 Mid-run reset: 2 words in channel 0, pull reset low between edges -> valid_out=0, data_out=0, drop_count=0 immediately; after release, write data_in=4 to channel 0 -> data_out[0]=4, not an old word.
